// File: rtl/axi_burst_reader.sv
// AXI4 read engine: splits a byte-length transfer into INCR bursts that
// respect a per-burst beat cap and never cross a 4 KB page, then forwards
// the read data as a zero-latency valid/ready stream.
//
// state  | meaning
// IDLE   | waiting for rmst_req
// ADDR   | presenting one AR request, waiting for arready
// DATA   | receiving the beats of the outstanding burst
// DONE   | one-cycle rmst_done pulse
module axi_burst_reader #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MAX_BURST_BEATS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rmst_req,
    input  logic [ADDR_WIDTH-1:0] addr_offset,
    input  logic [63:0]           xfer_size,
    output logic                  rmst_done,
    output logic                  rd_err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  valid,
    input  logic                  ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [8:0] MAX_N  = 9'(MAX_BURST_BEATS);
    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [57:0]           rem_q, rem_d;
    logic [8:0]            n_q, n_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  rd_err_q, rd_err_d;

    logic                  in_data;
    logic                  beat_acc;
    logic                  last_beat;
    logic [6:0]            page_beats;
    logic [8:0]            cap;

    // Only the 64 B-aligned part of the start address is meaningful.
    logic                  unused_addr_lsb;
    assign unused_addr_lsb = ^addr_offset[5:0];

    assign in_data   = (state_q == S_DATA);
    assign beat_acc  = in_data & m_axi_rvalid & ready;
    assign last_beat = (beat_cnt_q == 9'd1);

    // Next-state, address/remaining-count and error bookkeeping.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        rd_err_d   = rd_err_q;
        case (state_q)
            S_IDLE: begin
                if (rmst_req) begin
                    addr_d   = {addr_offset[ADDR_WIDTH-1:6], 6'b0};
                    rem_d    = xfer_size[63:6] + 58'(|xfer_size[5:0]);
                    rd_err_d = 1'b0;
                    state_d  = (rem_d == 58'd0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    beat_cnt_d = n_q;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    rem_d      = rem_q - 58'd1;
                    if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat)) begin
                        rd_err_d = 1'b1;
                    end
                    if (last_beat) begin
                        addr_d  = addr_q + (ADDR_WIDTH'(n_q) << 6);
                        state_d = (rem_q == 58'd1) ? S_DONE : S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst length for the next AR: limited by remaining beats, the beat cap
    // and the distance to the next 4 KB page boundary.
    always_comb begin
        page_beats = 7'd64 - {1'b0, addr_d[11:6]};
        cap        = (MAX_N < {2'b00, page_beats}) ? MAX_N : {2'b00, page_beats};
        n_d        = (rem_d < {49'b0, cap}) ? rem_d[8:0] : cap;
    end

    // State and datapath registers; n is captured on every entry to ADDR so
    // the AR fields stay stable while arvalid is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            n_q        <= 9'd1;
            beat_cnt_q <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            rd_err_q   <= rd_err_d;
            if ((state_d == S_ADDR) && (state_q != S_ADDR)) begin
                n_q <= n_d;
            end
        end
    end

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(n_q - 9'd1);
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_ADDR);
    assign m_axi_rready  = in_data & ready;
    assign valid         = in_data & m_axi_rvalid;
    assign tdata         = m_axi_rdata;
    assign rmst_done     = (state_q == S_DONE);
    assign rd_err        = rd_err_q;

endmodule

// File: doc/axi_burst_reader.md
# axi_burst_reader

Upstream AXI4 read engine for the input buffer. Accepts a transfer request (`rmst_req`, `addr_offset`, `xfer_size`), splits it into INCR bursts of at most `MAX_BURST_BEATS` beats that never cross a 4 KB boundary, and forwards read data as a valid/ready stream (`tdata`/`valid`/`ready`). Completion is reported with a one-cycle `rmst_done` pulse. One burst is outstanding at a time.

## Interface
- `DATA_WIDTH`, 512, AXI read data width in bits; beat = `DATA_WIDTH/8` = 64 B.
- `ADDR_WIDTH`, 64, AXI address width.
- `MAX_BURST_BEATS`, 64, maximum beats per AR, in the range 1..256.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rmst_req`  in  1  start pulse; sampled only in IDLE.
- `addr_offset`  in  64  start byte address; must be 64 B aligned, and the low 6 bits are ignored.
- `xfer_size`  in  64  transfer length in bytes; rounded up to whole beats.
- `rmst_done`  out  1  one-cycle pulse when the transfer completes.
- `rd_err`  out  1  sticky error flag; set by RRESP≠OKAY or an RLAST mismatch; cleared by an accepted `rmst_req`.
- `m_axi_araddr`  out  ADDR_WIDTH  burst address.
- `m_axi_arlen`  out  8  beats−1.
- `m_axi_arsize`  out  3  constant log2(DATA_WIDTH/8).
- `m_axi_arburst`  out  2  constant 2'b01 (INCR).
- `m_axi_arvalid`  out  1  AR valid.
- `m_axi_arready`  in  1  AR ready.
- `m_axi_rdata`  in  DATA_WIDTH  read data.
- `m_axi_rresp`  in  2  read response.
- `m_axi_rlast`  in  1  last beat.
- `m_axi_rvalid`  in  1  R valid.
- `m_axi_rready`  out  1  R ready.
- `tdata`  out  DATA_WIDTH  stream data to the input buffer, combinational from `m_axi_rdata`.
- `valid`  out  1  stream valid.
- `ready`  in  1  stream ready; this is the input-buffer FIFO not-full signal.

## Operation
- **States:** IDLE, ADDR, DATA, DONE.
- **IDLE:**
  - When `rmst_req`=1, latch `addr = {addr_offset[63:6], 6'b0}` and `rem = ceil(xfer_size/64)`. The `rem` counter is 58 bits.
  - Clear `rd_err`.
  - If `rem`==0, go to DONE. Otherwise go to ADDR.
- **Burst size:**
  - `n = min(rem, MAX_BURST_BEATS, (4096 − addr[11:0]) >> 6)`.
  - `n` is computed and registered on entry to ADDR.
  - `m_axi_arlen = n−1` and `m_axi_araddr = addr`.
- **ADDR:**
  - Hold `m_axi_arvalid`=1 with stable `m_axi_araddr`/`m_axi_arlen` until `m_axi_arready`.
  - On handshake, go to DATA and load `beat_cnt = n`.
- **DATA:**
  - `m_axi_rready = ready`.
  - `valid = m_axi_rvalid`.
  - `tdata = m_axi_rdata`.
  - A beat is accepted when `m_axi_rvalid & ready`. Each accepted beat decrements `beat_cnt` and `rem`.
  - The final beat is decided by `beat_cnt`==1, not by `m_axi_rlast`.
  - If `m_axi_rlast` disagrees with `beat_cnt`==1 on an accepted beat, set `rd_err`.
  - On the final beat: `addr += n*64`. If `rem` becomes 0, go to DONE; else go to ADDR.
- **DONE:** `rmst_done`=1 for exactly one cycle, then IDLE.
- **Outside DATA:** `m_axi_rready`=0 and `valid`=0.
- **Ignored requests:** `rmst_req` in any state other than IDLE is ignored. It is neither queued nor errored.
- **Error handling:** an RRESP≠OKAY beat sets `rd_err` but its data is still forwarded. The transfer always runs to its computed length.

## Timing
- **Reset values:**
  - `m_axi_arvalid`=0, `m_axi_araddr`=0, `m_axi_arlen`=0, `rmst_done`=0, `rd_err`=0.
  - `m_axi_rready`=0, `valid`=0, state=IDLE.
  - `m_axi_arsize` and `m_axi_arburst` are constants.
- **Reset mid-operation:** state returns to IDLE next cycle and any in-flight burst is abandoned. The AXI slave must be reset together with this block.
- **Request to address latency:** `rmst_req` at cycle T gives `m_axi_arvalid`=1 at T+1.
- **Zero-length request:** `rmst_req` at cycle T gives `rmst_done` at T+1 and no AR is issued.
- **Address to data:** AR handshake at cycle A makes `m_axi_rready` able to assert from A+1.
- **Completion:** final-beat handshake at cycle D gives `rmst_done` at D+1 and IDLE at D+2.
- **Chained bursts:** final beat of a non-last burst at cycle D gives the next `m_axi_arvalid` at D+1.
- **Data path:** zero latency, no storage. Backpressure from `ready` propagates combinationally to `m_axi_rready`.
- **Throughput:** one beat per cycle while `ready` and `m_axi_rvalid` are both high.

## Test plan
- **Single full burst:** `addr_offset`=0x1000, `xfer_size`=4096 → one AR with araddr=0x1000 and arlen=63; 64 `valid` beats; `rmst_done` pulse; `rd_err`=0.
- **Multi-burst with partial tail:** `xfer_size`=63232 from 0x0 → 15 ARs with arlen=63, then one AR with arlen=27; total 988 beats; addresses step by 0x1000; exactly one `rmst_done`.
- **4 KB split:** `addr_offset`=0xFC0, `xfer_size`=256 → AR(0xFC0, arlen 0) then AR(0x1000, arlen 2); 4 beats total.
- **Backpressure:** `ready` low for 10 cycles mid-burst → `m_axi_rready` low for those same cycles; no beat lost or duplicated; output data sequence matches memory.
- **Zero size and ignored request:**
  - `xfer_size`=0 → `rmst_done` at T+1 with no `m_axi_arvalid`.
  - A second `rmst_req` during DATA → ignored, only one `rmst_done`.
- **Errors:**
  - RRESP=SLVERR on beat 5 → `rd_err`=1 and held through completion, all beats still forwarded; cleared by the next accepted `rmst_req`.
  - Early `m_axi_rlast` → `rd_err`=1 while the beat count is still honoured.
